// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the packet-aware round-robin stream arbiter.
package stream_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b01,
        LOCKED = 2'b10
    } state_t;

    function automatic int calc_id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request after ptr, wrapping at NUM_REQ-1.
module rr_picker #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = stream_arb_pkg::calc_id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [ID_WIDTH-1:0] i_ptr,
    output logic [ID_WIDTH-1:0] o_pick,
    output logic                o_any
);

    // One extra bit so start + offset (up to 2*NUM_REQ-1) never overflows.
    localparam int SW = ID_WIDTH + 1;

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [SW-1:0]        start;
    logic [SW-1:0]        offset;
    logic [SW-1:0]        sum;

    always_comb begin
        req_dbl = {i_req, i_req};
        start   = {1'b0, i_ptr} + SW'(1);
        offset  = '0;
        // Reading the doubled vector from 'start' is the rotate; the
        // descending loop leaves the lowest set offset as the winner.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_dbl[start + SW'(i)]) begin
                offset = SW'(i);
            end
        end
        sum = start + offset;
        if (sum >= SW'(NUM_REQ)) begin
            sum = sum - SW'(NUM_REQ);
        end
        o_pick = ID_WIDTH'(sum);
    end

    assign o_any = |i_req;

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready stream among NUM_REQ requesters.
// Define STREAM_ARB_PKT_LOCK_EN to hold each grant until the last beat; otherwise arbitration is per beat.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = calc_id_width(NUM_REQ)
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_clear,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
    input  logic [NUM_REQ-1:0]            i_valid,
    input  logic [NUM_REQ-1:0]            i_last,
    output logic [NUM_REQ-1:0]            o_ready,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_last,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [ID_WIDTH-1:0]           o_grant_id,
    output logic                          o_busy
);

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;

    logic [ID_WIDTH-1:0]   pick;
    logic                  any_req;
    logic                  stage_free;
    logic                  accept;
    logic [DATA_WIDTH-1:0] req_data [NUM_REQ];

    rr_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .i_req  (i_valid),
        .i_ptr  (ptr_q),
        .o_pick (pick),
        .o_any  (any_req)
    );

    // Combinational i_ready -> o_ready path lets a packet stream at full rate.
    assign stage_free = !valid_q || i_ready;
    assign accept     = (state_q == LOCKED) && i_valid[grant_q] && stage_free;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_data[gi] = i_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign o_ready[gi]  = (state_q == LOCKED) && (grant_q == ID_WIDTH'(gi)) && stage_free;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = LOCKED;
                    grant_d = pick;
                    busy_d  = 1'b1;
                end
            end
            LOCKED: begin
                if (accept) begin
                    data_d  = req_data[grant_q];
                    last_d  = i_last[grant_q];
                    valid_d = 1'b1;
`ifdef STREAM_ARB_PKT_LOCK_EN
                    if (i_last[grant_q]) begin
                        state_d = IDLE;
                        ptr_d   = grant_q;
                        busy_d  = 1'b0;
                    end
`else
                    state_d = IDLE;
                    ptr_d   = grant_q;
                    busy_d  = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            state_q <= IDLE;
            ptr_q   <= ID_WIDTH'(NUM_REQ - 1);
            grant_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_last     = last_q;
    assign o_grant_id = grant_q;
    assign o_busy     = busy_q;

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Packet-aware round-robin arbiter that shares one valid/ready output stream among NUM_REQ requester streams.
- Each grant is held until the granted requester's last beat.
- The output side is a single registered stage, so o_data, o_valid and o_last are flop outputs.
- Sits in front of a downstream skid buffer or FIFO on a shared resource, e.g. a memory write port or a link.

Parameters:
- NUM_REQ, 4, number of requester streams (>=2).
- DATA_WIDTH, 32, beat width in bits.
- ID_WIDTH, $clog2(NUM_REQ), width of the grant index (derived; not overridden).

Ports:
- i_clock  in  1  rising-edge clock.
- i_reset  in  1  synchronous active-high reset.
- i_clear  in  1  synchronous flush; same effect as i_reset.
- i_data  in  NUM_REQ*DATA_WIDTH  requester beats; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_valid  in  NUM_REQ  per-requester valid.
- i_last  in  NUM_REQ  per-requester end-of-packet flag.
- o_ready  out  NUM_REQ  per-requester ready.
- o_data  out  DATA_WIDTH  output beat.
- o_last  out  1  output end-of-packet flag.
- o_valid  out  1  output valid.
- i_ready  in  1  downstream ready.
- o_grant_id  out  ID_WIDTH  currently granted requester.
- o_busy  out  1  high while in LOCKED.

Behaviour:
- Reset values (i_reset or i_clear at a clock edge):
  - state = IDLE; o_valid = 0; o_data = 0; o_last = 0; o_grant_id = 0; o_busy = 0.
  - Priority pointer ptr = NUM_REQ-1, so requester 0 wins first.
- Handshakes:
  - Input accept[k] = i_valid[k] && o_ready[k].
  - Output transmit = o_valid && i_ready.
  - Output stage may load when stage_free = !o_valid || i_ready. This is a combinational path from i_ready to o_ready, and it is permitted.
- State machine:
  - IDLE:
    - All o_ready = 0.
    - If any i_valid is set, pick the first set bit scanning ptr+1, ptr+2, ... modulo NUM_REQ.
    - Next cycle: state = LOCKED, o_grant_id = pick, o_busy = 1.
    - Result: one arbitration bubble per packet.
  - LOCKED (grant g):
    - o_ready[g] = stage_free; all other o_ready = 0.
    - On accept[g]: o_data <= beat g, o_last <= i_last[g], o_valid <= 1.
    - If accept[g] && i_last[g]: state <= IDLE, ptr <= g, o_busy <= 0.
- Output stage clearing:
  - On transmit without a new accept, o_valid <= 0.
  - o_data and o_last hold their value when not loading.
- Throughput and latency:
  - Inside a packet: one beat per cycle when the downstream is always ready.
  - Input-to-output latency: 1 cycle.
- Boundaries:
  - Single-beat packets (i_last=1 on the first beat) release the grant immediately. Back-to-back single-beat packets reach 50% throughput because of the IDLE bubble.
  - When one requester is continuously valid, fairness comes from the pointer: after its packet, the other valid requesters are served before it again.
  - If the granted requester drops valid mid-packet, the grant holds; the protocol forbids this, and the block does not recover.
  - Non-granted i_valid never affects the output.
  - Reset or clear mid-packet discards the in-flight beat and the partial packet. The lock is released.
  - NUM_REQ not a power of two: the pointer wraps at NUM_REQ-1 to 0, and unused encodings are never produced.

Optional Feature:
- Macro: STREAM_ARB_PKT_LOCK_EN.
- Defined:
  - Behaviour as above; the grant is held until the last beat.
- Undefined:
  - i_last is passed to o_last only; it does not control the grant.
  - Every accepted beat returns to IDLE, with ptr <= g (beat-level round-robin).
  - o_busy is high only during the cycle of a beat transfer.

Decomposition:
- Package stream_arb_pkg:
  - state_t enum (IDLE, LOCKED), one-hot, 2 bits.
  - Function that computes ID_WIDTH from NUM_REQ.
- Sub-module rr_picker (combinational), parameterised on NUM_REQ:
  - Inputs: request vector, ptr.
  - Outputs: pick index, any_req.
  - Implemented as a double-width rotate and priority encode.

Test Plan:
- Reset, then hold i_valid = 4'b0000 for 5 cycles -> o_valid = 0, o_ready = 0, o_busy = 0, o_grant_id = 0.
- i_valid = 4'b1111, each requester sends a 3-beat packet tagged 0xA0+k, i_ready = 1 -> grant order 0,1,2,3. Beats appear 1 cycle after acceptance, 3 per packet, with one idle cycle between packets. o_last is set on the 3rd beat of each packet.
- Requester 2 alone, 4-beat packet; i_ready toggles 1,0,1,0 -> no beat lost or duplicated, o_data holds while i_ready=0, and output order is 0xC0..0xC3.
- Requesters 1 and 3 continuously valid with single-beat packets -> grants alternate 1,3,1,3, so neither requester is starved.
- Assert i_reset mid-way through a 4-beat packet from requester 0 -> the next cycle has o_valid = 0 and o_busy = 0. The next grant goes to the lowest-indexed valid requester (ptr = NUM_REQ-1).
- STREAM_ARB_PKT_LOCK_EN undefined, requesters 0 and 1 each sending 2-beat packets -> output beats interleave 0,1,0,1, and o_last is passed through unchanged.
